// File: rtl/clock_time_ctrl.sv
// Strobe sequencer for the HH:MM:SS digit counter bank: RUN carry chain,
// hour/minute set modes, blink phase and a post-strobe settle window.
module clock_time_ctrl #(
    parameter int BLINK_DIV = 1
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] sec_lo,
    input  logic [3:0] sec_hi,
    input  logic [3:0] min_lo,
    input  logic [3:0] min_hi,
    input  logic [3:0] hr_lo,
    input  logic [3:0] hr_hi,
    output logic [5:0] digit_en,
    output logic [5:0] digit_clr_n,
    output logic [1:0] mode,
    output logic       blink
);

    localparam logic [1:0] RUN     = 2'b00;
    localparam logic [1:0] SET_HR  = 2'b01;
    localparam logic [1:0] SET_MIN = 2'b10;

    localparam int DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BLINK_DIV - 1);

    logic [1:0]    busy_q;
    logic [DW-1:0] div_q;

    logic idle;
    logic go_mode;
    logic go_inc;
    logic go_tick;
    logic blink_tick;

    assign idle       = (busy_q == 2'd0);
    assign go_mode    = idle & btn_mode;
    assign go_inc     = idle & btn_inc & ~btn_mode;
    assign go_tick    = idle & tick & ~btn_mode & ~btn_inc;
    assign blink_tick = idle & tick;

    // ">=" so an out-of-range digit wraps on its next carry
    logic sl_top, sh_top, ml_top, mh_top, hl_top;
    logic sec_59, min_59, hr_23;

    assign sl_top = (sec_lo >= 4'd9);
    assign sh_top = (sec_hi >= 4'd5);
    assign ml_top = (min_lo >= 4'd9);
    assign mh_top = (min_hi >= 4'd5);
    assign hl_top = (hr_lo >= 4'd9);
    assign sec_59 = sl_top & sh_top;
    assign min_59 = ml_top & mh_top;
    assign hr_23  = ((hr_hi >= 4'd2) & (hr_lo >= 4'd3))
                  | (hr_hi >= 4'd3);

    logic [1:0] sc_en, sc_clr;
    logic [1:0] mn_en, mn_clr;
    logic [1:0] hr_en, hr_clr;

    always_comb begin
        sc_en  = {sl_top & ~sh_top, ~sl_top};
        sc_clr = {sl_top & sh_top, sl_top};
        mn_en  = {ml_top & ~mh_top, ~ml_top};
        mn_clr = {ml_top & mh_top, ml_top};
        hr_en  = 2'b00;
        hr_clr = 2'b00;
        if (hr_23) begin
            hr_clr = 2'b11;
        end else if (hl_top) begin
            hr_clr = 2'b01;
            hr_en  = 2'b10;
        end else begin
            hr_en = 2'b01;
        end
    end

    logic [5:0] en_d;
    logic [5:0] clr_d;
    logic [1:0] mode_d;

    always_comb begin
        en_d   = 6'b0;
        clr_d  = 6'b0;
        mode_d = (mode == 2'b11) ? RUN : mode;
        unique case (1'b1)
            go_mode: begin
                if (mode == RUN) begin
                    mode_d     = SET_HR;
                    clr_d[1:0] = 2'b11;
                end else if (mode == SET_HR) begin
                    mode_d = SET_MIN;
                end else begin
                    mode_d = RUN;
                end
            end
            go_inc: begin
                if (mode == SET_HR) begin
                    en_d[5:4]  = hr_en;
                    clr_d[5:4] = hr_clr;
                end else if (mode == SET_MIN) begin
                    en_d[3:2]  = mn_en;
                    clr_d[3:2] = mn_clr;
                end
            end
            go_tick: begin
                if (mode == RUN) begin
                    en_d[1:0]  = sc_en;
                    clr_d[1:0] = sc_clr;
                    if (sec_59) begin
                        en_d[3:2]  = mn_en;
                        clr_d[3:2] = mn_clr;
                    end
                    if (sec_59 & min_59) begin
                        en_d[5:4]  = hr_en;
                        clr_d[5:4] = hr_clr;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            digit_en    <= 6'b0;
            digit_clr_n <= 6'h3F;
            mode        <= RUN;
            busy_q      <= 2'd0;
        end else begin
            digit_en    <= en_d;
            digit_clr_n <= ~clr_d;
            mode        <= mode_d;
            if (idle & (tick | btn_mode | btn_inc)) begin
                busy_q <= 2'd2;
            end else if (!idle) begin
                busy_q <= busy_q - 2'd1;
            end
        end
    end

    // divider only runs while a field is being set
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            blink <= 1'b0;
            div_q <= '0;
        end else if (mode_d == RUN) begin
            blink <= 1'b0;
            div_q <= '0;
        end else if (blink_tick && mode != RUN) begin
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                blink <= ~blink;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Scoreboard bench for clock_time_ctrl: directed events push expected
// strobe/mode/blink words; a negedge monitor pops on any visible output.
module tb_clock_time_ctrl;

    logic       clock = 1'b0;
    logic       clear;
    logic       tick, btn_mode, btn_inc;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
    logic [5:0] digit_en, digit_clr_n;
    logic [1:0] mode;
    logic       blink;

    clock_time_ctrl #(.BLINK_DIV(2)) dut (
        .clock      (clock),
        .clear      (clear),
        .tick       (tick),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .sec_lo     (sec_lo),
        .sec_hi     (sec_hi),
        .min_lo     (min_lo),
        .min_hi     (min_hi),
        .hr_lo      (hr_lo),
        .hr_hi      (hr_hi),
        .digit_en   (digit_en),
        .digit_clr_n(digit_clr_n),
        .mode       (mode),
        .blink      (blink)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [14:0] v;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;
    logic [1:0] last_mode = 2'b00;
    logic       last_blink = 1'b0;

    task automatic push(input string n, input logic [5:0] en,
                        input logic [5:0] cn, input logic [1:0] m,
                        input logic b);
        exp_t e;
        e.name = n;
        e.v = {en, cn, m, b};
        q.push_back(e);
    endtask

    always @(negedge clock) begin
        logic [14:0] cur;
        exp_t e;
        cur = {digit_en, digit_clr_n, mode, blink};
        if (mon_en && (digit_en != 6'b0 || digit_clr_n != 6'h3F ||
                       mode != last_mode || blink != last_blink)) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected: en=%b clr_n=%b mode=%b blink=%b, none required",
                         digit_en, digit_clr_n, mode, blink);
            end else begin
                e = q.pop_front();
                if (e.v !== cur) begin
                    n_bad++;
                    $display("FAIL %s: got en=%b clr_n=%b mode=%b blink=%b, required en=%b clr_n=%b mode=%b blink=%b",
                             e.name, digit_en, digit_clr_n, mode, blink,
                             e.v[14:9], e.v[8:3], e.v[2:1], e.v[0]);
                end
            end
        end
        last_mode  = mode;
        last_blink = blink;
    end

    task automatic chk(input string n, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", n, act, exp);
        end
    endtask

    task automatic set_time(input logic [3:0] hh, input logic [3:0] hl,
                            input logic [3:0] mh, input logic [3:0] ml,
                            input logic [3:0] sh, input logic [3:0] sl);
        hr_hi = hh; hr_lo = hl;
        min_hi = mh; min_lo = ml;
        sec_hi = sh; sec_lo = sl;
    endtask

    task automatic ev(input logic t, input logic m, input logic i);
        tick = t; btn_mode = m; btn_inc = i;
        @(posedge clock);
        #1;
        tick = 0; btn_mode = 0; btn_inc = 0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, required finish");
        $fatal(1);
    end

    initial begin
        clear = 1'b0;
        tick = 0; btn_mode = 0; btn_inc = 0;
        set_time(0, 0, 0, 0, 0, 0);
        gap(2);
        chk("rst_en", {2'b0, digit_en}, 8'h00);
        chk("rst_clr_n", {2'b0, digit_clr_n}, 8'h3F);
        chk("rst_mode", {6'b0, mode}, 8'h00);
        chk("rst_blink", {7'b0, blink}, 8'h00);
        clear = 1'b1;
        gap(1);
        mon_en = 1'b1;

        set_time(0, 0, 0, 0, 0, 0);
        push("tick_000000", 6'b000001, 6'h3F, 2'b00, 1'b0);
        ev(1, 0, 0); gap(3);

        set_time(0, 0, 0, 0, 3, 9);
        push("tick_000039", 6'b000010, 6'b111110, 2'b00, 1'b0);
        ev(1, 0, 0); gap(3);

        set_time(0, 0, 0, 0, 0, 4'hC);
        push("tick_sec_oor", 6'b000010, 6'b111110, 2'b00, 1'b0);
        ev(1, 0, 0); gap(3);

        set_time(0, 0, 0, 9, 5, 9);
        push("tick_000959", 6'b001000, 6'b111000, 2'b00, 1'b0);
        ev(1, 0, 0); gap(3);

        set_time(1, 2, 5, 9, 5, 9);
        push("tick_125959", 6'b010000, 6'b110000, 2'b00, 1'b0);
        ev(1, 0, 0); gap(3);

        set_time(1, 9, 5, 9, 5, 9);
        push("tick_195959", 6'b100000, 6'b100000, 2'b00, 1'b0);
        ev(1, 0, 0); gap(3);

        set_time(2, 3, 5, 9, 5, 9);
        push("tick_235959", 6'b000000, 6'b000000, 2'b00, 1'b0);
        ev(1, 0, 0); gap(3);

        set_time(2, 4, 5, 9, 5, 9);
        push("tick_hr_oor", 6'b000000, 6'b000000, 2'b00, 1'b0);
        ev(1, 0, 0); gap(3);

        set_time(2, 3, 4, 5, 3, 7);
        push("enter_set_hr", 6'b000000, 6'b111100, 2'b01, 1'b0);
        ev(0, 1, 0); gap(3);

        push("inc_hr_23", 6'b000000, 6'b001111, 2'b01, 1'b0);
        ev(0, 0, 1); gap(3);

        set_time(0, 7, 4, 5, 3, 7);
        push("inc_hr_07", 6'b010000, 6'h3F, 2'b01, 1'b0);
        ev(0, 0, 1); gap(3);

        push("enter_set_min", 6'b000000, 6'h3F, 2'b10, 1'b0);
        ev(0, 1, 0); gap(3);

        set_time(0, 7, 5, 9, 3, 7);
        push("inc_min_59", 6'b000000, 6'b110011, 2'b10, 1'b0);
        ev(0, 0, 1); gap(3);

        set_time(0, 7, 3, 4, 3, 7);
        push("inc_min_34", 6'b000100, 6'h3F, 2'b10, 1'b0);
        ev(0, 0, 1); gap(3);

        ev(1, 0, 0);
        ev(0, 0, 1);
        gap(3);

        push("exit_set_min", 6'b000000, 6'h3F, 2'b00, 1'b0);
        ev(0, 1, 0); gap(3);

        set_time(0, 0, 0, 0, 0, 0);
        push("tick_then_busy", 6'b000001, 6'h3F, 2'b00, 1'b0);
        ev(1, 0, 0); gap(1);
        ev(1, 0, 0); gap(3);

        set_time(0, 0, 0, 0, 3, 7);
        push("all_three", 6'b000000, 6'b111100, 2'b01, 1'b0);
        ev(1, 1, 1); gap(3);

        for (int k = 1; k <= 6; k++) begin
            if (k % 2 == 0)
                push($sformatf("blink_t%0d", k), 6'b0, 6'h3F, 2'b01,
                     (k % 4 == 2) ? 1'b1 : 1'b0);
            ev(1, 0, 0); gap(3);
        end

        push("blink_to_min", 6'b000000, 6'h3F, 2'b10, 1'b1);
        ev(0, 1, 0); gap(3);
        push("blink_to_run", 6'b000000, 6'h3F, 2'b00, 1'b0);
        ev(0, 1, 0); gap(3);

        mon_en = 1'b0;
        set_time(0, 0, 0, 0, 0, 0);
        ev(1, 0, 0);
        chk("pre_rst_en", {2'b0, digit_en}, 8'h01);
        clear = 1'b0;
        #1;
        chk("mid_rst_en", {2'b0, digit_en}, 8'h00);
        chk("mid_rst_clr_n", {2'b0, digit_clr_n}, 8'h3F);
        gap(1);
        clear = 1'b1;
        gap(2);

        chk("queue_empty", 8'(q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
